// File: rtl/lr_classify_seq.sv
// lr_classify_seq: one-vs-all logistic-regression scorer for 81-feature frames.
// A single multiply-accumulate walks every (class, feature) pair in turn.
// Each class's 32-bit score is published on hidden, and the arg-max class
// with its score is reported at the end of the frame.
module lr_classify_seq #(
    parameter int NFEAT  = 81,
    parameter int NCLASS = 10,
    parameter int XW     = 7,
    parameter int TW     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic [6:0]    x_addr,
    input  logic [XW-1:0] x_data,
    output logic [10:0]   theta_addr,
    input  logic [TW-1:0] theta_data,
    output logic          hidden_valid,
    output logic [31:0]   hidden,
    output logic [3:0]    hidden_class,
    output logic          done,
    output logic [3:0]    class_id,
    output logic [31:0]   score
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_CMP   = 2'd3;

    localparam logic [6:0] LAST_F = 7'(NFEAT - 1);
    localparam logic [3:0] LAST_C = 4'(NCLASS - 1);

    logic [1:0]  state;
    logic [3:0]  issue_c;
    logic        rd_valid;
    logic [6:0]  rd_f;
    logic [3:0]  rd_c;
    logic [31:0] acc;
    logic [31:0] prod;
    logic [31:0] sum;
    logic [31:0] best_score;
    logic [3:0]  best_class;
    logic [31:0] nxt_score;
    logic [3:0]  nxt_class;
    logic        take_new;

    // Product of the returned pixel and weight; the bias feature uses 1.0 in Q16
    always_comb begin
        prod = 32'd0;
        if (rd_f == 7'd0) begin
            prod = 32'(theta_data) << 16;
        end else begin
            prod = {{(32-XW){1'b0}}, x_data} * 32'(theta_data);
        end
        sum = (rd_f == 7'd0) ? prod : acc + prod;
    end

    // Running best: class 0 always loads, later classes must be strictly greater
    always_comb begin
        take_new  = (hidden_class == 4'd0) || ($signed(hidden) > $signed(best_score));
        nxt_score = take_new ? hidden : best_score;
        nxt_class = take_new ? hidden_class : best_class;
    end

    // Frame sequencing and address issue, one (class, feature) pair per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            x_addr     <= 7'd0;
            theta_addr <= 11'd0;
            issue_c    <= 4'd0;
            rd_valid   <= 1'b0;
            rd_f       <= 7'd0;
            rd_c       <= 4'd0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    x_addr     <= 7'd0;
                    theta_addr <= 11'd0;
                    issue_c    <= 4'd0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    rd_valid <= 1'b1;
                    rd_f     <= x_addr;
                    rd_c     <= issue_c;
                    if (x_addr == LAST_F) begin
                        x_addr <= 7'd0;
                        if (issue_c == LAST_C) begin
                            state      <= S_DRAIN;
                            theta_addr <= 11'd0;
                            issue_c    <= 4'd0;
                        end else begin
                            theta_addr <= theta_addr + 11'd1;
                            issue_c    <= issue_c + 4'd1;
                        end
                    end else begin
                        x_addr     <= x_addr + 7'd1;
                        theta_addr <= theta_addr + 11'd1;
                    end
                end
                S_DRAIN: begin
                    if (hidden_valid && (hidden_class == LAST_C)) begin
                        state <= S_CMP;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Accumulate returned products and publish each finished class score
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= 32'd0;
            hidden       <= 32'd0;
            hidden_class <= 4'd0;
            hidden_valid <= 1'b0;
        end else begin
            hidden_valid <= 1'b0;
            if (rd_valid) begin
                acc <= sum;
                if (rd_f == LAST_F) begin
                    hidden       <= sum;
                    hidden_class <= rd_c;
                    hidden_valid <= 1'b1;
                end
            end
        end
    end

    // Track the best class and latch the final result when the last class lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score <= 32'd0;
            best_class <= 4'd0;
            class_id   <= 4'd0;
            score      <= 32'd0;
        end else if (hidden_valid) begin
            best_score <= nxt_score;
            best_class <= nxt_class;
            if (hidden_class == LAST_C) begin
                class_id <= nxt_class;
                score    <= nxt_score;
            end
        end
    end

endmodule

// File: tb/tb_lr_classify_seq.sv
// Scoreboard bench for lr_classify_seq: directed frames push expected class
// scores and final results; a monitor pops them as the DUT presents outputs.
module tb_lr_classify_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic [6:0]  x_addr;
    logic [6:0]  x_data;
    logic [10:0] theta_addr;
    logic [31:0] theta_data;
    logic        hidden_valid;
    logic [31:0] hidden;
    logic [3:0]  hidden_class;
    logic        done;
    logic [3:0]  class_id;
    logic [31:0] score;

    typedef struct {
        bit          is_done;
        int          cls;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [6:0]  pix[81];
    logic [31:0] theta_mem[810];
    int          total;
    int          bad;
    longint      t0;
    int          cur_n;

    lr_classify_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .x_addr(x_addr), .x_data(x_data),
        .theta_addr(theta_addr), .theta_data(theta_data),
        .hidden_valid(hidden_valid), .hidden(hidden), .hidden_class(hidden_class),
        .done(done), .class_id(class_id), .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer and theta ROM with one cycle of read latency
    always @(posedge clk) begin
        x_data     <= pix[x_addr];
        theta_data <= theta_mem[theta_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic clear_mem(input logic [6:0] p);
        for (int i = 0; i < 81; i++) pix[i] = p;
        for (int i = 0; i < 810; i++) theta_mem[i] = 32'd0;
    endtask

    task automatic push_hidden(input int c, input logic [31:0] v);
        exp_t e;
        e.is_done = 1'b0; e.cls = c; e.val = v; e.cyc = 81 * c + 83;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic [31:0] v);
        exp_t e;
        e.is_done = 1'b1; e.cls = c; e.val = v; e.cyc = 813;
        exp_q.push_back(e);
    endtask

    // Monitor: every hidden_valid or done pulse must match the queue head
    always @(negedge clk) begin
        exp_t e;
        cur_n = int'(($time - t0 + 5) / 10);
        if (rst_n === 1'b1 && (hidden_valid === 1'b1 || done === 1'b1)) begin
            checkOutput("queue_has_entry", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pulse_kind", {31'd0, done}, {31'd0, e.is_done});
                checkOutput("pulse_cycle", 32'(cur_n), 32'(e.cyc));
                if (e.is_done) begin
                    checkOutput("class_id", {28'd0, class_id}, 32'(e.cls));
                    checkOutput("score", score, e.val);
                end else begin
                    checkOutput("hidden_class", {28'd0, hidden_class}, 32'(e.cls));
                    checkOutput("hidden", hidden, e.val);
                end
            end
        end
    end

    // Run one frame, checking address order and busy; optionally inject
    // ignored starts, chain a new start at n=814, or reset mid-frame
    task automatic applyStimulus(input int reset_at, input bit poke, input bit chain, input bit pre_started);
        int addr_err;
        int first_bad;
        addr_err  = 0;
        first_bad = -1;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        t0 = $time;
        #1 start = 1'b0;
        for (int n = 1; n <= 814; n++) begin
            @(negedge clk);
            if (reset_at != 0 && n == reset_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                checkOutput("rst_x_addr", {25'd0, x_addr}, 32'd0);
                checkOutput("rst_theta_addr", {21'd0, theta_addr}, 32'd0);
                checkOutput("rst_hidden", hidden, 32'd0);
                checkOutput("rst_hidden_class", {28'd0, hidden_class}, 32'd0);
                checkOutput("rst_hidden_valid", {31'd0, hidden_valid}, 32'd0);
                return;
            end
            if (n <= 810) begin
                if (x_addr !== 7'((n - 1) % 81) || theta_addr !== 11'(n - 1) || busy !== 1'b1) begin
                    addr_err++;
                    if (first_bad < 0) first_bad = n;
                end
            end
            if (n == 813) checkOutput("busy_at_813", {31'd0, busy}, 32'd1);
            if (n == 814) checkOutput("busy_at_814", {31'd0, busy}, 32'd0);
            start = poke && (n == 400 || n == 813);
            if (n == 814 && chain) start = 1'b1;
        end
        if (addr_err != 0) $display("[TB] first address/busy error at cycle %0d", first_bad);
        checkOutput("addr_order", 32'(addr_err), 32'd0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        t0    = 0;
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem(7'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_done", {31'd0, done}, 32'd0);
        checkOutput("idle_hidden_valid", {31'd0, hidden_valid}, 32'd0);
        checkOutput("idle_x_addr", {25'd0, x_addr}, 32'd0);
        checkOutput("idle_theta_addr", {21'd0, theta_addr}, 32'd0);
        checkOutput("idle_hidden", hidden, 32'd0);
        checkOutput("idle_hidden_class", {28'd0, hidden_class}, 32'd0);
        checkOutput("idle_class_id", {28'd0, class_id}, 32'd0);
        checkOutput("idle_score", score, 32'd0);

        $display("[TB] single class winner");
        clear_mem(7'd10);
        for (int f = 1; f < 81; f++) theta_mem[3*81+f] = 32'd1;
        for (int c = 0; c < 10; c++) push_hidden(c, (c == 3) ? 32'd800 : 32'd0);
        push_done(3, 32'd800);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] bias and sign");
        clear_mem(7'd0);
        for (int c = 0; c < 10; c++) begin
            theta_mem[c*81] = 32'(c - 5);
            for (int f = 1; f < 81; f++) theta_mem[c*81+f] = 32'h0000_1234;
        end
        push_hidden(0, 32'hFFFB_0000);
        push_hidden(1, 32'hFFFC_0000);
        push_hidden(2, 32'hFFFD_0000);
        push_hidden(3, 32'hFFFE_0000);
        push_hidden(4, 32'hFFFF_0000);
        push_hidden(5, 32'h0000_0000);
        push_hidden(6, 32'h0001_0000);
        push_hidden(7, 32'h0002_0000);
        push_hidden(8, 32'h0003_0000);
        push_hidden(9, 32'h0004_0000);
        push_done(9, 32'd262144);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] tie keeps lower index");
        clear_mem(7'd5);
        theta_mem[2*81+1] = 32'd100;
        theta_mem[7*81+5] = 32'd100;
        theta_mem[4*81+1] = -32'sd3;
        for (int c = 0; c < 10; c++)
            push_hidden(c, (c == 2 || c == 7) ? 32'd500 : (c == 4) ? 32'hFFFF_FFF1 : 32'd0);
        push_done(2, 32'd500);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("[TB] wrap, ignored starts, back-to-back frame");
        clear_mem(7'd127);
        theta_mem[4*81+1] = 32'h7FFF_FFFF;
        for (int c = 0; c < 10; c++) push_hidden(c, (c == 4) ? 32'h7FFF_FF81 : 32'd0);
        push_done(4, 32'h7FFF_FF81);
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) push_hidden(c, (c == 4) ? 32'h7FFF_FF81 : 32'd0);
        push_done(4, 32'h7FFF_FF81);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("chained_busy", {31'd0, busy}, 32'd0);

        $display("[TB] reset mid-frame");
        clear_mem(7'd5);
        theta_mem[2*81+1] = 32'd100;
        theta_mem[7*81+5] = 32'd100;
        push_hidden(0, 32'd0);
        push_hidden(1, 32'd0);
        push_hidden(2, 32'd500);
        applyStimulus(300, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("reset_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("reset_done_low", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (520) @(negedge clk);
        checkOutput("reset_no_done_class", {28'd0, class_id}, 32'd0);
        for (int c = 0; c < 10; c++) push_hidden(c, (c == 2 || c == 7) ? 32'd500 : 32'd0);
        push_done(2, 32'd500);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
